apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB completer (responder) for the 3-bit-address, 5-bit-data APB bus driven by the team's APB master.
- Decodes setup/enable phases and inserts a parameterised number of wait states via pready.
- Holds a small register file for write and read transfers.
- Sits at the far end of the master's psel/penable/pwrite/padd/pwdata bus; returns prdata and pready.

Parameters:
- ADDR_W, 3, address width (matches master padd).
- DATA_W, 5, data width (matches master pwdata/prdata).
- NUM_REGS, 6, implemented registers at addresses 0..NUM_REGS-1; addresses NUM_REGS..2^ADDR_W-1 are unmapped.
- WAIT_STATES, 1, enable-phase cycles with pready low before completion (0..7).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- preset  in  1  reset, asynchronous, active-high.
- psel  in  1  slave select from master.
- penable  in  1  enable phase from master.
- pwrite  in  1  1 = write, 0 = read.
- padd  in  ADDR_W  transfer address.
- pwdata  in  DATA_W  write data.
- pready  out  1  transfer-complete indication, registered.
- prdata  out  DATA_W  read data, registered.
- pslverr  out  1  error response; present only with APB_SLVERR_EN.

Behaviour:
- Reset (preset=1, async):
  - state=IDLE; pready=0; prdata=0; pslverr=0; wait counter=0.
  - All NUM_REGS registers are cleared to 0.
  - Reset in the middle of a transfer aborts it; no register write occurs.
- Setup detect: psel=1 & penable=0 sampled at a rising edge.
  - The slave captures padd, pwrite and pwdata into internal registers.
  - All later decisions for that transfer use the captured values.
- FSM states: IDLE, WAIT, READY.
  - IDLE: on setup detect -> READY if WAIT_STATES=0 (pready=1 next cycle), else -> WAIT with counter=WAIT_STATES.
    - Outputs in IDLE: pready=0, prdata=0.
  - WAIT: each edge with psel=1 & penable=1 decrements the counter.
    - On the edge where the counter goes 1->0: -> READY and pready<=1.
    - If this is a mapped read, prdata<=reg[addr] on the same edge, so prdata is valid whenever pready=1.
  - READY: pready=1.
    - On the edge with psel=1 & penable=1 the transfer completes.
    - On completion, a mapped write sets reg[addr]<=captured pwdata.
    - After completion: pready<=0, prdata<=0, -> IDLE.
  - Abort: psel=0 in WAIT or READY -> IDLE, pready=0, no write.
- Latency:
  - WAIT_STATES=0: pready=1 in the first enable cycle.
  - Otherwise pready=1 in enable cycle WAIT_STATES+1.
  - Total transfer length is WAIT_STATES+2 cycles.
- Back-to-back: the master may issue a new setup in the cycle right after completion. It is taken from IDLE with no bubble beyond the setup cycle.
- Same-address write followed by read returns the newly written value.
- Unmapped address (addr >= NUM_REGS): the transfer completes with normal wait timing; a read returns 0; a write is ignored.
- penable=1 with psel=0 is ignored.

Optional Feature:
- Macro: APB_SLVERR_EN.
- Defined:
  - The pslverr port exists.
  - pslverr=1 exactly while pready=1 for an unmapped access; otherwise 0.
  - Unmapped writes are suppressed and unmapped reads return prdata=0.
- Undefined:
  - No pslverr port.
  - Unmapped accesses complete silently: read 0, write ignored.

Test Plan:
- Reset: set preset=1 mid-WAIT -> pready=0, prdata=0 immediately; a later read of addr 0 returns 0.
- Write then read, WAIT_STATES=1: write addr 2 data 5'h15, then read addr 2 -> prdata=5'h15 with pready=1 in the 2nd enable cycle of the read; pready low in the 1st enable cycle.
- Zero wait, WAIT_STATES=0: write addr 5 data 5'h1F, then back-to-back read addr 5 -> pready=1 in the first enable cycle of each transfer; read returns 5'h1F.
- Abort: psel dropped in WAIT during a write of 5'h0A to addr 1 -> FSM returns to IDLE; a read of addr 1 returns the old value 0.
- Unmapped: write 5'h07 to addr 6, then read addr 6 -> prdata=0.
  - With APB_SLVERR_EN: pslverr=1 only in the pready cycle of both transfers.
  - Without APB_SLVERR_EN: no error signalled.
- Burst: write addrs 0..5 with values 1..6, then read all back -> values match and no other register is corrupted.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB completer with a small register file and a fixed number of wait states.
// Every transfer is decoded in setup, held low on pready for WAIT_STATES enable
// cycles, then completed. Addresses at or above NUM_REGS read 0 and ignore writes.
// Optional macro APB_SLVERR_EN adds a pslverr port, asserted alongside pready for
// unmapped accesses.
module apb_slave_regfile #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned DATA_W      = 5,
    parameter int unsigned NUM_REGS    = 6,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] padd,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata
`ifdef APB_SLVERR_EN
    ,
    output logic              pslverr
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

    // One extra bit so NUM_REGS == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] NumRegsW = NUM_REGS[ADDR_W:0];
    localparam logic [2:0]      WaitInit = WAIT_STATES[2:0];

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                setup, access, capture;
    logic [ADDR_W-1:0]   idx_sel;
    logic                wr_sel, sel_mapped;
    logic [DATA_W-1:0]   rd_val;
    logic                pready_d, wr_en;
    logic [DATA_W-1:0]   prdata_d;
`ifdef APB_SLVERR_EN
    logic                pslverr_d;
`endif

    assign setup   = psel & ~penable;
    assign access  = psel & penable;
    assign capture = (state_q == StIdle) && setup;

    // In IDLE the transfer is not captured yet, so a zero-wait read looks at the live bus.
    assign idx_sel    = (state_q == StIdle) ? padd : addr_q;
    assign wr_sel     = (state_q == StIdle) ? pwrite : write_q;
    assign sel_mapped = ({1'b0, idx_sel} < NumRegsW);
    assign rd_val     = sel_mapped ? regs_q[idx_sel] : '0;

    // State register.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (setup) state_d = (WAIT_STATES == 0) ? StReady : StWait;
            end
            StWait: begin
                if (!psel)                          state_d = StIdle;
                else if (penable && cnt_q == 3'd1)  state_d = StReady;
            end
            StReady: begin
                if (!psel || penable) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, wait counter and write strobe.
    always_comb begin
        pready_d = 1'b0;
        prdata_d = '0;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
`ifdef APB_SLVERR_EN
        pslverr_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    cnt_d = WaitInit;
                    if (WAIT_STATES == 0) begin
                        pready_d = 1'b1;
                        prdata_d = wr_sel ? '0 : rd_val;
`ifdef APB_SLVERR_EN
                        pslverr_d = ~sel_mapped;
`endif
                    end
                end
            end
            StWait: begin
                if (!psel) begin
                    cnt_d = '0;
                end else if (penable) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        pready_d = 1'b1;
                        prdata_d = wr_sel ? '0 : rd_val;
`ifdef APB_SLVERR_EN
                        pslverr_d = ~sel_mapped;
`endif
                    end
                end
            end
            StReady: begin
                if (access) begin
                    wr_en = write_q & sel_mapped;
                end else if (psel) begin
                    // Master has not raised penable yet: keep the response steady.
                    pready_d = pready;
                    prdata_d = prdata;
`ifdef APB_SLVERR_EN
                    pslverr_d = pslverr;
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs, transfer capture, counter and register file.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            pready  <= 1'b0;
            prdata  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
`ifdef APB_SLVERR_EN
            pslverr <= 1'b0;
`endif
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            pready <= pready_d;
            prdata <= prdata_d;
            cnt_q  <= cnt_d;
`ifdef APB_SLVERR_EN
            pslverr <= pslverr_d;
`endif
            if (capture) begin
                addr_q  <= padd;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
            if (wr_en) regs_q[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: one instance with one wait state, one with zero wait states,
// sharing the bus except for psel. Outputs are sampled on the falling edge.
module tb_apb_slave_regfile;

    logic       clk = 1'b0;
    logic       preset;
    logic       psel0, psel1, penable, pwrite;
    logic [2:0] padd;
    logic [4:0] pwdata;
    logic       pready0, pready1;
    logic [4:0] prdata0, prdata1;
    logic       pslverr0, pslverr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_slave_regfile #(.ADDR_W(3), .DATA_W(5), .NUM_REGS(6), .WAIT_STATES(1)) u_dut1 (
        .clk(clk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .padd(padd), .pwdata(pwdata), .pready(pready1), .prdata(prdata1)
`ifdef APB_SLVERR_EN
        , .pslverr(pslverr1)
`endif
    );

    apb_slave_regfile #(.ADDR_W(3), .DATA_W(5), .NUM_REGS(6), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .padd(padd), .pwdata(pwdata), .pready(pready0), .prdata(prdata0)
`ifdef APB_SLVERR_EN
        , .pslverr(pslverr0)
`endif
    );

`ifndef APB_SLVERR_EN
    assign pslverr0 = 1'b0;
    assign pslverr1 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit which);
        return which ? pready1 : pready0;
    endfunction

    function automatic logic [4:0] dat(input bit which);
        return which ? prdata1 : prdata0;
    endfunction

    function automatic logic err_of(input bit which);
        return which ? pslverr1 : pslverr0;
    endfunction

    // Setup cycle then first enable cycle; returns at the negedge inside enable cycle 1.
    task automatic setup_enable(input bit which, input bit wr, input logic [2:0] a,
                                input logic [4:0] d);
        @(negedge clk);
        if (which) psel1 = 1'b1; else psel0 = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        padd    = a;
        pwdata  = d;
        @(negedge clk);
        penable = 1'b1;
    endtask

    // Runs until pready is seen; the completing edge follows with the bus still held.
    task automatic xfer(input bit which, input bit wr, input logic [2:0] a, input logic [4:0] d,
                        output logic [4:0] rd, output int lat, output logic err,
                        output logic err_early);
        setup_enable(which, wr, a, d);
        lat = 1;
        err_early = 1'b0;
        while (!rdy(which) && lat < 20) begin
            err_early |= err_of(which);
            @(negedge clk);
            lat++;
        end
        rd  = dat(which);
        err = err_of(which);
    endtask

    task automatic idle(input bit which);
        @(negedge clk);
        psel0   = 1'b0;
        psel1   = 1'b0;
        penable = 1'b0;
        check("done_pready_low", {31'b0, rdy(which)}, 32'd0);
        check("done_pslverr_low", {31'b0, err_of(which)}, 32'd0);
    endtask

    logic [4:0] rd;
    int         lat;
    logic       err, err_early;

    initial begin
        preset = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; padd = '0; pwdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pready1", {31'b0, pready1}, 32'd0);
        check("rst_prdata1", {27'b0, prdata1}, 32'd0);
        check("rst_pready0", {31'b0, pready0}, 32'd0);
        check("rst_pslverr1", {31'b0, pslverr1}, 32'd0);
        preset = 1'b0;

        // Write then read with one wait state.
        xfer(1'b1, 1'b1, 3'd2, 5'h15, rd, lat, err, err_early);
        check("wr2_latency", lat, 32'd2);
        idle(1'b1);
        xfer(1'b1, 1'b0, 3'd2, 5'h00, rd, lat, err, err_early);
        check("rd2_latency", lat, 32'd2);
        check("rd2_data", {27'b0, rd}, 32'h15);
        idle(1'b1);

        // Abort a write in WAIT by dropping psel.
        setup_enable(1'b1, 1'b1, 3'd1, 5'h0A);
        check("abort_wait_pready", {31'b0, pready1}, 32'd0);
        psel1 = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check("abort_idle_pready", {31'b0, pready1}, 32'd0);
        xfer(1'b1, 1'b0, 3'd1, 5'h00, rd, lat, err, err_early);
        check("abort_rd1_latency", lat, 32'd2);
        check("abort_rd1_data", {27'b0, rd}, 32'h00);
        idle(1'b1);

        // Unmapped write and read.
        xfer(1'b1, 1'b1, 3'd6, 5'h07, rd, lat, err, err_early);
        check("unmap_wr_latency", lat, 32'd2);
`ifdef APB_SLVERR_EN
        check("unmap_wr_err", {31'b0, err}, 32'd1);
        check("unmap_wr_err_early", {31'b0, err_early}, 32'd0);
`endif
        idle(1'b1);
        xfer(1'b1, 1'b0, 3'd6, 5'h00, rd, lat, err, err_early);
        check("unmap_rd_latency", lat, 32'd2);
        check("unmap_rd_data", {27'b0, rd}, 32'h00);
`ifdef APB_SLVERR_EN
        check("unmap_rd_err", {31'b0, err}, 32'd1);
        check("unmap_rd_err_early", {31'b0, err_early}, 32'd0);
`endif
        idle(1'b1);

        // Back-to-back burst: regs 0..5 <= 1..6, then read all back plus address 7.
        for (int i = 0; i < 6; i++) begin
            xfer(1'b1, 1'b1, 3'(i), 5'(i + 1), rd, lat, err, err_early);
            check("burst_wr_latency", lat, 32'd2);
            check("burst_wr_err", {31'b0, err}, 32'd0);
        end
        idle(1'b1);
        for (int i = 0; i < 6; i++) begin
            xfer(1'b1, 1'b0, 3'(i), 5'h00, rd, lat, err, err_early);
            check("burst_rd_data", {27'b0, rd}, 32'(i + 1));
        end
        xfer(1'b1, 1'b0, 3'd7, 5'h00, rd, lat, err, err_early);
        check("burst_rd7_data", {27'b0, rd}, 32'h00);
        idle(1'b1);

        // Asynchronous reset while a read is presenting data in READY.
        xfer(1'b1, 1'b0, 3'd3, 5'h00, rd, lat, err, err_early);
        check("ready_rd3_data", {27'b0, rd}, 32'h04);
        #2 preset = 1'b1;
        #1;
        check("rst_ready_pready", {31'b0, pready1}, 32'd0);
        check("rst_ready_prdata", {27'b0, prdata1}, 32'h00);
        @(negedge clk);
        preset = 1'b0; psel1 = 1'b0; penable = 1'b0;

        // Asynchronous reset mid-WAIT of a write.
        setup_enable(1'b1, 1'b1, 3'd0, 5'h0C);
        #2 preset = 1'b1;
        #1;
        check("rst_wait_pready", {31'b0, pready1}, 32'd0);
        check("rst_wait_prdata", {27'b0, prdata1}, 32'h00);
        @(negedge clk);
        preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
        xfer(1'b1, 1'b0, 3'd0, 5'h00, rd, lat, err, err_early);
        check("rst_rd0_data", {27'b0, rd}, 32'h00);
        idle(1'b1);

        // Zero wait states: back-to-back write then read.
        xfer(1'b0, 1'b1, 3'd5, 5'h1F, rd, lat, err, err_early);
        check("zw_wr_latency", lat, 32'd1);
        xfer(1'b0, 1'b0, 3'd5, 5'h00, rd, lat, err, err_early);
        check("zw_rd_latency", lat, 32'd1);
        check("zw_rd_data", {27'b0, rd}, 32'h1F);
        idle(1'b0);
        xfer(1'b0, 1'b0, 3'd7, 5'h00, rd, lat, err, err_early);
        check("zw_unmap_latency", lat, 32'd1);
        check("zw_unmap_data", {27'b0, rd}, 32'h00);
`ifdef APB_SLVERR_EN
        check("zw_unmap_err", {31'b0, err}, 32'd1);
`endif
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
